// File: rtl/binary_matvec_seq_if.sv
// Handshake bundle for binary_matvec_seq:
// row-load port, vector input port and result output port.
interface binary_matvec_seq_if #(
  parameter int N  = 4,
  parameter int IW = (N <= 2) ? 1 : $clog2(N)
);
  logic          ld_valid;
  logic          ld_ready;
  logic [IW-1:0] ld_idx;
  logic [N-1:0]  ld_row;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_vec;
  logic          in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_vec;
  logic          busy;

  modport master (
    output ld_valid, ld_idx, ld_row,
    output in_valid, in_vec, in_mode,
    output out_ready,
    input  ld_ready, in_ready,
    input  out_valid, out_vec, busy
  );

  modport slave (
    input  ld_valid, ld_idx, ld_row,
    input  in_valid, in_vec, in_mode,
    input  out_ready,
    output ld_ready, in_ready,
    output out_valid, out_vec, busy
  );
endinterface

// File: rtl/binary_matvec_seq.sv
// Row-serial NxN binary matrix-vector multiplier,
// GF(2) (AND/XOR) or Boolean (AND/OR) reduction.
module binary_matvec_seq #(
  parameter int N  = 4,
  parameter int IW = (N <= 2) ? 1 : $clog2(N)
) (
  input logic clk,
  input logic rst_n,
  binary_matvec_seq_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  mat [N];
  logic [N-1:0]  vlat;
  logic          mode;
  logic [IW-1:0] cnt;
  logic [N-1:0]  res;
  logic [N-1:0]  prod;
  logic          row_bit;
  logic          idle;
  logic          ld_fire;

  assign idle    = (state == IDLE);
  assign ld_fire = idle && bus.ld_valid;

  assign bus.in_ready  = idle;
  assign bus.ld_ready  = idle;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = !idle;
  assign bus.out_vec   = res;

  always_comb begin
    prod    = mat[cnt] & vlat;
    row_bit = mode ? |prod : ^prod;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      vlat  <= '0;
      mode  <= 1'b0;
      cnt   <= '0;
      res   <= '0;
      for (int i = 0; i < N; i++) begin
        mat[i] <= '0;
      end
    end else begin
      // out-of-range rows are taken but dropped
      if (ld_fire && int'(bus.ld_idx) < N) begin
        mat[bus.ld_idx] <= bus.ld_row;
      end
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            vlat  <= bus.in_vec;
            mode  <= bus.in_mode;
            cnt   <= '0;
            res   <= '0;
            state <= COMPUTE;
          end
        end
        COMPUTE: begin
          res[cnt] <= row_bit;
          cnt      <= cnt + 1'b1;
          if (cnt == IW'(N - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
